// File: rtl/apb_mailbox_pkg.sv
// Register map and bit positions shared by the APB mailbox and its bench.
// The irq feature (APB_MAILBOX_IRQ_EN) uses CTRL_IRQ_EN below.
package apb_mailbox_pkg;

    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_TX_DATA = 2'd1,
        REG_RX_DATA = 2'd2,
        REG_CTRL    = 2'd3
    } apb_mailbox_reg_t;

    localparam int STAT_TX_CNT_LSB = 0;
    localparam int STAT_RX_EMPTY   = 8;
    localparam int STAT_TX_FULL    = 9;
    localparam int STAT_RX_OVF     = 10;
    localparam int STAT_RX_CNT_LSB = 16;

    localparam int CTRL_TX_FLUSH = 0;
    localparam int CTRL_RX_FLUSH = 1;
    localparam int CTRL_OVF_CLR  = 2;
    localparam int CTRL_IRQ_EN   = 3;

    function automatic logic [7:0] sat8(input logic [15:0] v);
        return (v > 16'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/apb_if.sv
// APB bus bundle; the mailbox uses the completer view.
// pclk/preset_n are carried for completeness only.
interface APB #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32
) ();
    logic                    pclk;
    logic                    preset_n;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport completer (
        input  pclk, preset_n, paddr, psel, penable,
        input  pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );

    modport requester (
        output pclk, preset_n, paddr, psel, penable,
        output pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_mailbox_fifo.sv
// First-word-fall-through FIFO with synchronous flush and occupancy count.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module SingleClockFifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointers and count; flush overrides any push/pop this cycle.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage write; a flushed push is discarded.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
    end
endmodule

// File: rtl/apb_mailbox.sv
// APB mailbox: TX/RX word FIFOs behind a four-register APB window.
// Define APB_MAILBOX_IRQ_EN to add the irq output and CTRL.irq_en.
module apb_mailbox
    import apb_mailbox_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int ADDR_WIDTH = 24
) (
    input  logic        clk,
    input  logic        rst,
    APB.completer       apb,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_data,
    input  logic        rx_valid,
    input  logic [31:0] rx_data
`ifdef APB_MAILBOX_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] addr;
    apb_mailbox_reg_t      reg_sel;
    logic [CW-1:0]         tx_count, rx_count;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic [31:0]           rx_head;
    logic                  accept, tx_pop, tx_push, rx_pop, ovf_evt;
    logic                  tx_flush, rx_flush, ovf_clr;
    logic [31:0]           status, ctrl_rd, rsp_data;
    logic                  rsp_err;
    logic                  pready_q, pslverr_q, busy_q, ovf_q;
    logic [31:0]           prdata_q;
    logic                  irq_en_q, irq_en_d;
    logic                  unused_ok;

    assign addr      = apb.paddr;
    assign reg_sel   = apb_mailbox_reg_t'(addr[3:2]);
    assign unused_ok = ^{apb.pclk, apb.preset_n, apb.pstrb, addr};

    // One access per psel/penable assertion; busy_q blocks a held request.
    assign accept = apb.psel && apb.penable && !pready_q && !busy_q;

    assign tx_valid = !tx_empty && !rst;
    assign tx_pop   = tx_valid && tx_ready;
    assign ovf_evt  = rx_valid && rx_full && !rx_pop && !rx_flush;

    assign status = {16'(rx_count), 5'b0, ovf_q, tx_full, rx_empty,
                     sat8(16'(tx_count))};

`ifdef APB_MAILBOX_IRQ_EN
    assign ctrl_rd = 32'(irq_en_q) << CTRL_IRQ_EN;
`else
    assign ctrl_rd = '0;
`endif

    // Register decode and side effects of the accepted access.
    always_comb begin
        tx_push  = 1'b0;
        rx_pop   = 1'b0;
        tx_flush = 1'b0;
        rx_flush = 1'b0;
        ovf_clr  = 1'b0;
        irq_en_d = irq_en_q;
        rsp_data = '0;
        rsp_err  = 1'b0;
        if (accept) begin
            unique case (reg_sel)
                REG_STATUS: begin
                    if (apb.pwrite) rsp_err  = 1'b1;
                    else            rsp_data = status;
                end
                REG_TX_DATA: begin
                    if (apb.pwrite && (!tx_full || tx_pop)) tx_push = 1'b1;
                    else                                    rsp_err = 1'b1;
                end
                REG_RX_DATA: begin
                    if (apb.pwrite || rx_empty) begin
                        rsp_err = 1'b1;
                    end else begin
                        rsp_data = rx_head;
                        rx_pop   = 1'b1;
                    end
                end
                REG_CTRL: begin
                    if (apb.pwrite) begin
                        tx_flush = apb.pwdata[CTRL_TX_FLUSH];
                        rx_flush = apb.pwdata[CTRL_RX_FLUSH];
                        ovf_clr  = apb.pwdata[CTRL_OVF_CLR];
`ifdef APB_MAILBOX_IRQ_EN
                        irq_en_d = apb.pwdata[CTRL_IRQ_EN];
`endif
                    end else begin
                        rsp_data = ctrl_rd;
                    end
                end
            endcase
        end
    end

    // Response registers, sticky overflow and irq enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
        end else begin
            pready_q  <= accept;
            pslverr_q <= rsp_err;
            prdata_q  <= rsp_data;
            busy_q    <= apb.psel && apb.penable;
            ovf_q     <= (ovf_q && !ovf_clr) || ovf_evt;
            irq_en_q  <= irq_en_d;
        end
    end

`ifdef APB_MAILBOX_IRQ_EN
    logic irq_q;

    // Level interrupt on pending RX data or overflow.
    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_en_q && (!rx_empty || ovf_q);
    end

    assign irq = irq_q;
`endif

    // Outputs read as idle for as long as reset is held.
    assign apb.pready  = pready_q && !rst;
    assign apb.pslverr = pslverr_q && !rst;
    assign apb.prdata  = rst ? '0 : prdata_q;

    SingleClockFifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32), .CW(CW)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (tx_flush),
        .push_i  (tx_push),
        .wdata_i (apb.pwdata),
        .pop_i   (tx_pop),
        .rdata_o (tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    SingleClockFifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32), .CW(CW)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (rx_flush),
        .push_i  (rx_valid),
        .wdata_i (rx_data),
        .pop_i   (rx_pop),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );
endmodule
